// File: rtl/cen_gen_pkg.sv
// rtl/cen_gen_pkg.sv - shared constants and helpers for the fractional clock-enable generator
package cen_gen_pkg;

   // cfg_sel encodings
   localparam logic [1:0] CFG_INC = 2'd0;
   localparam logic [1:0] CFG_MOD = 2'd1;
   localparam logic [1:0] CFG_EN  = 2'd2;
   localparam logic [1:0] CFG_RSV = 2'd3;

   localparam int DEF_ACC_W = 16;

   // Widest packed default vector the unpack helper accepts (16 channels x 32 bits)
   localparam int MAX_CH = 16;
   localparam int MAX_W  = 32;
   localparam int PACK_W = MAX_CH * MAX_W;

   // Extract channel ch's w-bit field from a packed per-channel default (ch0 in LSBs).
   // The caller truncates the returned word to its own width.
   function automatic logic [MAX_W-1:0] unpack_def(input logic [PACK_W-1:0] vec,
                                                   input int ch, input int w);
      logic [PACK_W-1:0] sh;
      sh = vec >> (ch * w);
      return sh[MAX_W-1:0];
   endfunction

endpackage

// File: rtl/cen_gen_frac_ch.sv
// rtl/cen_gen_frac_ch.sv - one fractional accumulator channel producing a registered enable strobe
module cen_gen_frac_ch
   import cen_gen_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W
)(
   input  logic             refclk,
   input  logic             rst,
   input  logic [ACC_W-1:0] inc,
   input  logic [ACC_W-1:0] mod,
   input  logic             en,
   input  logic             run,
   input  logic             clr,
   output logic             cen,
   output logic             err
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;
   logic             legal;

   // Legality of the current settings and the widened next-sum (no overflow at ACC_W+1 bits)
   always_comb begin
      legal = (mod != '0) && (inc <= mod);
      sum   = {1'b0, acc} + {1'b0, inc};
   end

   // Illegal-config flag, one cycle behind the register it describes
   always_ff @(posedge refclk) begin
      if (rst) begin
         err <= 1'b0;
      end else begin
         err <= ~legal;
      end
   end

   // Accumulator: cleared while unlocked, resyncing, illegal or rewritten; frozen while disabled
   always_ff @(posedge refclk) begin
      if (rst) begin
         acc <= '0;
         cen <= 1'b0;
      end else if (clr || !run || !legal) begin
         acc <= '0;
         cen <= 1'b0;
      end else if (!en) begin
         cen <= 1'b0;
      end else if (sum >= {1'b0, mod}) begin
         acc <= ACC_W'(sum - {1'b0, mod});
         cen <= 1'b1;
      end else begin
         acc <= sum[ACC_W-1:0];
         cen <= 1'b0;
      end
   end

endmodule

// File: rtl/cen_gen_frac.sv
// rtl/cen_gen_frac.sv - multi-channel fractional clock-enable generator with lock and resync
module cen_gen_frac
   import cen_gen_pkg::*;
#(
   parameter int                      NUM_CH      = 4,
   parameter int                      ACC_W       = DEF_ACC_W,
   parameter logic [NUM_CH*ACC_W-1:0] DEF_INC     = {NUM_CH{16'd1}},
   parameter logic [NUM_CH*ACC_W-1:0] DEF_MOD     = {NUM_CH{16'd2}},
   parameter int                      LOCK_CYCLES = 64,
   localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
   input  logic              refclk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [1:0]        cfg_sel,
   input  logic [ACC_W-1:0]  cfg_data,
   input  logic              resync,
   output logic [NUM_CH-1:0] cen,
   output logic [NUM_CH-1:0] cfg_err,
   output logic              locked
);

   localparam int               CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   logic [ACC_W-1:0]  inc_r [NUM_CH];
   logic [ACC_W-1:0]  mod_r [NUM_CH];
   logic [NUM_CH-1:0] en_r;
   logic [NUM_CH-1:0] clr;
   logic [CNT_W-1:0]  lock_cnt;
   logic              locked_r;
   logic              wr_act;
   logic              run;

   // A write counts only for a real register of an existing channel
   assign wr_act = cfg_we && (cfg_sel != CFG_RSV) && (int'(cfg_ch) < NUM_CH);
   assign run    = locked_r & ~resync;
   assign locked = locked_r;

   // One-hot decode of the written channel; that channel restarts from acc=0
   always_comb begin
      clr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         clr[i] = wr_act && (int'(cfg_ch) == i);
      end
   end

   // Per-channel configuration registers, restored to the packed defaults on reset
   always_ff @(posedge refclk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            inc_r[i] <= ACC_W'(unpack_def(PACK_W'(DEF_INC), i, ACC_W));
            mod_r[i] <= ACC_W'(unpack_def(PACK_W'(DEF_MOD), i, ACC_W));
         end
         en_r <= '1;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (clr[i]) begin
               case (cfg_sel)
                  CFG_INC: inc_r[i] <= cfg_data;
                  CFG_MOD: mod_r[i] <= cfg_data;
                  CFG_EN:  en_r[i]  <= cfg_data[0];
                  default: ;
               endcase
            end
         end
      end
   end

   // Lock counter: restarts on reset or any accepted write, locks after LOCK_CYCLES cycles
   always_ff @(posedge refclk) begin
      if (rst) begin
         lock_cnt <= '0;
         locked_r <= 1'b0;
      end else if (wr_act) begin
         lock_cnt <= '0;
         locked_r <= 1'b0;
      end else if (!locked_r) begin
         if (lock_cnt == CNT_LAST) begin
            locked_r <= 1'b1;
         end else begin
            lock_cnt <= lock_cnt + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      cen_gen_frac_ch #(
         .ACC_W (ACC_W)
      ) u_ch (
         .refclk (refclk),
         .rst    (rst),
         .inc    (inc_r[g]),
         .mod    (mod_r[g]),
         .en     (en_r[g]),
         .run    (run),
         .clr    (clr[g]),
         .cen    (cen[g]),
         .err    (cfg_err[g])
      );
   end

endmodule

// File: tb/tb_cen_gen_frac.sv
// tb/tb_cen_gen_frac.sv - scoreboard bench for cen_gen_frac with directed configuration vectors
module tb_cen_gen_frac;
   import cen_gen_pkg::*;

   localparam logic [3:0] F = 4'hF;
   localparam int S_CEN = 0, S_ERR = 1, S_LOCK = 2, S_WIN = 3;

   typedef struct {
      int         cyc;
      int         sig;
      logic [3:0] mask;
      int         val;
   } exp_t;

   logic        refclk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_ch = 2'd0;
   logic [1:0]  cfg_sel = 2'd0;
   logic [15:0] cfg_data = 16'd0;
   logic        resync = 1'b0;
   logic [3:0]  cen;
   logic [3:0]  cfg_err;
   logic        locked;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          b;
   exp_t        sbq[$];
   logic [24:0] hist = '0;

   cen_gen_frac #(
      .NUM_CH      (4),
      .ACC_W       (16),
      .LOCK_CYCLES (64)
   ) dut (
      .refclk   (refclk),
      .rst      (rst),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_sel  (cfg_sel),
      .cfg_data (cfg_data),
      .resync   (resync),
      .cen      (cen),
      .cfg_err  (cfg_err),
      .locked   (locked)
   );

   always #5 refclk = ~refclk;

   // Count rising edges so expectations can be scheduled by edge number
   always @(posedge refclk) cyc <= cyc + 1;

   function automatic string sig_name(input int s);
      case (s)
         S_CEN:   return "cen";
         S_ERR:   return "cfg_err";
         S_LOCK:  return "locked";
         default: return "ch1_window";
      endcase
   endfunction

   task automatic push_exp(input int c, input int sig, input logic [3:0] m, input int v);
      exp_t e;
      e.cyc  = c;
      e.sig  = sig;
      e.mask = m;
      e.val  = v;
      sbq.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic tick_to(input int c);
      tick(c - cyc);
   endtask

   task automatic cfg_write(input int ch, input logic [1:0] sel, input int data);
      cfg_we   = 1'b1;
      cfg_ch   = 2'(ch);
      cfg_sel  = sel;
      cfg_data = 16'(data);
      tick(1);
      cfg_we   = 1'b0;
   endtask

   // Monitor: pop every expectation due at this edge and compare against the sampled outputs
   always @(negedge refclk) begin
      exp_t e;
      int   act;
      hist = {hist[23:0], cen[1]};
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         e = sbq.pop_front();
         case (e.sig)
            S_CEN:   act = int'(cen & e.mask);
            S_ERR:   act = int'(cfg_err & e.mask);
            S_LOCK:  act = int'(locked);
            default: act = $countones(hist);
         endcase
         checks++;
         if (e.cyc != cyc) begin
            errors++;
            $display("FAIL %s stale: due edge %0d, seen edge %0d", sig_name(e.sig), e.cyc, cyc);
         end else if (act != e.val) begin
            errors++;
            $display("FAIL %s edge %0d: got %0d, expected %0d", sig_name(e.sig), cyc, act, e.val);
         end
      end
   end

   // Stimulus: each phase schedules its expectations, then drives the configuration
   initial begin
      // Reset and default 1/2 pattern on all channels
      tick(3);
      rst = 1'b0;
      b = cyc;
      push_exp(b, S_LOCK, F, 0);
      push_exp(b, S_CEN, F, 0);
      push_exp(b + 1, S_ERR, F, 0);
      push_exp(b + 63, S_LOCK, F, 0);
      push_exp(b + 64, S_LOCK, F, 1);
      push_exp(b + 64, S_CEN, F, 0);
      push_exp(b + 65, S_CEN, F, 0);
      push_exp(b + 66, S_CEN, F, 15);
      push_exp(b + 67, S_CEN, F, 0);
      push_exp(b + 68, S_CEN, F, 15);
      tick_to(b + 68);

      // ch1 = 12/25, re-lock, then the 12-in-25 window over 10000 active cycles
      b = cyc;
      for (int k = 1; k <= 66; k++) begin
         push_exp(b + k, S_CEN, F, 0);
         if (k == 1 || k == 65) push_exp(b + k, S_LOCK, F, 0);
         if (k == 3) push_exp(b + k, S_ERR, F, 0);
         if (k == 66) push_exp(b + k, S_LOCK, F, 1);
      end
      push_exp(b + 67, S_CEN, F, 0);
      push_exp(b + 68, S_CEN, F, 13);
      push_exp(b + 69, S_CEN, F, 2);
      push_exp(b + 70, S_CEN, F, 13);
      push_exp(b + 71, S_CEN, F, 2);
      for (int e = b + 91; e <= b + 10066; e++) push_exp(e, S_WIN, F, 12);
      cfg_write(1, CFG_INC, 12);
      cfg_write(1, CFG_MOD, 25);
      tick_to(b + 10066);

      // ch2 = 2/125, ch3 = 4/125, resync, then one full 125-cycle period
      b = cyc;
      push_exp(b + 67, S_LOCK, F, 0);
      push_exp(b + 68, S_LOCK, F, 1);
      push_exp(b + 101, S_CEN, 4'b1100, 0);
      push_exp(b + 101, S_LOCK, F, 1);
      for (int k = 1; k <= 125; k++) begin
         int v;
         v = ((k == 63 || k == 125) ? 4 : 0) |
             ((k == 32 || k == 63 || k == 94 || k == 125) ? 8 : 0);
         push_exp(b + 101 + k, S_CEN, 4'b1100, v);
         if (k == 1) push_exp(b + 101 + k, S_LOCK, F, 1);
      end
      cfg_write(2, CFG_MOD, 125);
      cfg_write(2, CFG_INC, 2);
      cfg_write(3, CFG_MOD, 125);
      cfg_write(3, CFG_INC, 4);
      tick_to(b + 100);
      resync = 1'b1;
      tick(1);
      resync = 1'b0;
      tick_to(b + 226);

      // Illegal configs on ch0 (mod=0) and ch1 (inc>mod), then repair
      b = cyc;
      push_exp(b + 1, S_CEN, 4'b0001, 0);
      push_exp(b + 1, S_ERR, 4'b0011, 0);
      for (int k = 2; k <= 70; k++) begin
         push_exp(b + k, S_CEN, 4'b0011, 0);
         if (k == 2) push_exp(b + k, S_ERR, 4'b0011, 1);
         if (k == 3) push_exp(b + k, S_ERR, 4'b0011, 3);
         if (k == 65) push_exp(b + k, S_LOCK, F, 0);
         if (k == 66) push_exp(b + k, S_LOCK, F, 1);
      end
      push_exp(b + 72, S_ERR, 4'b0011, 2);
      push_exp(b + 73, S_ERR, 4'b0011, 0);
      push_exp(b + 135, S_LOCK, F, 0);
      push_exp(b + 136, S_LOCK, F, 1);
      push_exp(b + 137, S_CEN, 4'b0011, 0);
      push_exp(b + 138, S_CEN, 4'b0011, 1);
      push_exp(b + 139, S_CEN, 4'b0011, 2);
      cfg_write(0, CFG_MOD, 0);
      cfg_write(1, CFG_INC, 30);
      tick_to(b + 70);
      cfg_write(0, CFG_MOD, 2);
      cfg_write(1, CFG_INC, 12);
      tick_to(b + 139);

      // Disable ch0 mid-run, then re-enable
      b = cyc;
      for (int k = 1; k <= 70; k++) begin
         push_exp(b + k, S_CEN, 4'b0001, 0);
         if (k == 64) push_exp(b + k, S_LOCK, F, 0);
         if (k == 65) push_exp(b + k, S_LOCK, F, 1);
         if (k == 68) push_exp(b + k, S_CEN, 4'b0010, 2);
      end
      push_exp(b + 134, S_LOCK, F, 0);
      push_exp(b + 135, S_LOCK, F, 1);
      push_exp(b + 136, S_CEN, 4'b0001, 0);
      push_exp(b + 137, S_CEN, 4'b0001, 1);
      push_exp(b + 138, S_CEN, 4'b0001, 0);
      cfg_write(0, CFG_EN, 0);
      tick_to(b + 70);
      cfg_write(0, CFG_EN, 1);
      tick_to(b + 138);

      // Reset mid-run with a concurrent write that must be ignored
      b = cyc;
      push_exp(b + 1, S_CEN, F, 0);
      push_exp(b + 1, S_LOCK, F, 0);
      push_exp(b + 2, S_CEN, F, 0);
      push_exp(b + 2, S_LOCK, F, 0);
      push_exp(b + 3, S_ERR, F, 0);
      push_exp(b + 65, S_LOCK, F, 0);
      push_exp(b + 66, S_LOCK, F, 1);
      push_exp(b + 67, S_CEN, F, 0);
      push_exp(b + 68, S_CEN, F, 15);
      push_exp(b + 69, S_CEN, F, 0);
      rst      = 1'b1;
      cfg_we   = 1'b1;
      cfg_ch   = 2'd0;
      cfg_sel  = CFG_MOD;
      cfg_data = 16'd0;
      tick(2);
      rst    = 1'b0;
      cfg_we = 1'b0;
      tick_to(b + 69);

      tick(2);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Bound on total run time
   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: edge %0d reached time limit, expected completion", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
